irq_arbiter: RTL
================

IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
- REQ-001: Parameter NCH, default 4: number of external interrupt channels, 1..8.
- REQ-002: Parameter ESW, default 4: EStatus width; NCH SHALL be <= 2^(ESW-1).
- REQ-003: clk  in  1  processor clock; all state updates on its rising edge.
- REQ-004: reset  in  1  asynchronous, active-high reset.
- REQ-005: irq_i  in  NCH  external interrupt sources; channel 0 has highest priority.
- REQ-006: mask_we  in  1  write strobe for the mask register.
- REQ-007: mask_wdata  in  NCH  new mask value; 1 = channel disabled.
- REQ-008: exc_req_i  in  1  synchronous internal exception request from the decoder.
- REQ-009: exc_code_i  in  ESW  internal exception code; its MSB SHALL be 0.
- REQ-010: ExcAck_i  in  1  datapath has redirected PC to the vector.
- REQ-011: eret_i  in  1  ERET executed; handler is finished.
- REQ-012: Exc_o  out  1  exception request to the controller.
- REQ-013: EStatus_o  out  ESW  cause of the current exception.
- REQ-014: ExtIAck_o  out  NCH  one-hot, one-cycle acknowledge to the served channel.
- REQ-015: busy_o  out  1  high in HANDLER state.
- REQ-016: dfault_o  out  1  sticky double-fault flag.

Function
- REQ-017: FSM SHALL have states IDLE, REQ and HANDLER.
- REQ-018: In IDLE with exc_req_i=1, the block SHALL latch EStatus=exc_code_i and enter REQ next cycle, regardless of pending IRQs.
- REQ-019: In IDLE with exc_req_i=0 and any (pending & ~mask), the block SHALL select the lowest-index winner k, latch EStatus=2^(ESW-1)+k and enter REQ.
- REQ-020: In REQ, Exc_o SHALL be 1 and EStatus_o held constant; mask writes or source deassertion SHALL NOT withdraw the request.
- REQ-021: In REQ with ExcAck_i=1, the block SHALL enter HANDLER next cycle; for an IRQ it SHALL pulse ExtIAck_o[k] for exactly that cycle and clear pending[k].
- REQ-022: Latency from qualifying event in IDLE to Exc_o=1 SHALL be exactly 1 cycle.
- REQ-023: In HANDLER, new IRQ events SHALL accumulate as pending without being served (no nesting).
- REQ-024: In HANDLER, eret_i=1 SHALL return the FSM to IDLE and clear EStatus_o to 0 on the next cycle.
- REQ-025: A pending IRQ SHALL be selectable on the first IDLE cycle after return.
- REQ-026: eret_i in IDLE or REQ, and ExcAck_i outside REQ, SHALL be ignored.
- REQ-027: exc_req_i in REQ or HANDLER SHALL set dfault_o; dfault_o SHALL clear only on reset.
- REQ-028: mask_we SHALL update the mask on the next edge; masked channels SHALL still record pending.
- REQ-029: Simultaneous set and clear of pending[k] in the same cycle: set SHALL win.

Reset
- REQ-030: On reset, the FSM SHALL be in IDLE and the mask all ones.
- REQ-031: On reset, pending, EStatus_o, ExtIAck_o, Exc_o, busy_o and dfault_o SHALL all be 0.
- REQ-032: Reset asserted mid-REQ or mid-HANDLER SHALL abort immediately, with no ExtIAck_o pulse.

Configuration
- REQ-033: With IRQ_EDGE_EN defined, pending[k] SHALL set on a 0->1 transition of irq_i[k] and clear per REQ-021.
- REQ-034: Without IRQ_EDGE_EN, pending SHALL equal irq_i (level-sensitive, no storage); the source SHALL deassert after ExtIAck_o.

Verification
- REQ-035: Unmask all, irq_i=4'b0110 -> Exc_o next cycle with EStatus_o=4'b1001; ExcAck_i -> ExtIAck_o=4'b0010 for one cycle, busy_o=1.
- REQ-036: exc_req_i=1 with code 4'b0011 and irq_i[0]=1 in the same IDLE cycle -> EStatus_o=4'b0011; the IRQ is served after eret_i with EStatus_o=4'b1000.
- REQ-037: In HANDLER, assert exc_req_i -> dfault_o=1 and it persists through eret_i until reset.
- REQ-038: Mask=4'b1111, irq_i[2] edge, then mask_we with 4'b0000 (IRQ_EDGE_EN) -> Exc_o one cycle after the mask write, EStatus_o=4'b1010.
- REQ-039: Reset pulse during REQ -> all outputs 0 asynchronously and no ExtIAck_o pulse.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter: single-level interrupt/exception arbiter with fixed priority.
//   A synchronous internal exception beats any pending external IRQ; among
//   IRQs the lowest unmasked channel index wins.
//   An accepted cause is latched into EStatus_o:
//     - internal exception: the raw exception code (MSB 0);
//     - IRQ on channel k:   2^(ESW-1) + k.
//   The cause is held while Exc_o is raised. After the datapath acknowledges,
//   the block sits in the handler state until ERET. Handlers do not nest.
//
// Build option:
//   IRQ_EDGE_EN  defined   -> pending bits latch on 0->1 edges of irq_i and
//                             clear when that channel is acknowledged.
//                undefined -> pending follows irq_i directly (level).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   irq_i      [NCH]      external interrupt sources (ch 0 = highest priority)
//   mask_we, mask_wdata   mask register write (1 = channel disabled)
//   exc_req_i, exc_code_i internal exception request and code
//   ExcAck_i              PC redirected to the vector
//   eret_i                handler finished
//   Exc_o                 exception request to the controller
//   EStatus_o  [ESW]      cause of the current exception
//   ExtIAck_o  [NCH]      one-hot, one-cycle acknowledge to the served channel
//   busy_o                handler in progress
//   dfault_o              sticky double-fault flag (cleared only by reset)
module irq_arbiter #(
  parameter int NCH = 4,
  parameter int ESW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] irq_i,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_wdata,
  input  logic           exc_req_i,
  input  logic [ESW-1:0] exc_code_i,
  input  logic           ExcAck_i,
  input  logic           eret_i,
  output logic           Exc_o,
  output logic [ESW-1:0] EStatus_o,
  output logic [NCH-1:0] ExtIAck_o,
  output logic           busy_o,
  output logic           dfault_o
);

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;

  state_t         state, state_d;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] active;
  logic [NCH-1:0] served, served_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic [ESW-1:0] estatus, estatus_d;
  logic           dfault;

  logic           win_found;
  logic [ESW-2:0] win_idx;
  logic [NCH-1:0] win_onehot;

`ifdef IRQ_EDGE_EN
  logic [NCH-1:0] irq_prev;

  // A new rising edge in the same cycle as the acknowledge keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= irq_i;
      pending  <= (pending & ~ack_d) | (irq_i & ~irq_prev);
    end
  end
`else
  assign pending = irq_i;
`endif

  assign active = pending & ~mask;

  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (active[i] && !win_found) begin
        win_found     = 1'b1;
        win_idx       = (ESW-1)'(i);
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    estatus_d = estatus;
    served_d  = served;
    ack_d     = '0;
    unique case (state)
      IDLE: begin
        if (exc_req_i) begin
          estatus_d = exc_code_i;
          served_d  = '0;
          state_d   = REQ;
        end else if (win_found) begin
          estatus_d = {1'b1, win_idx};
          served_d  = win_onehot;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (ExcAck_i) begin
          // served is zero for an internal exception, so no channel is acked
          ack_d   = served;
          state_d = HANDLER;
        end
      end
      HANDLER: begin
        if (eret_i) begin
          estatus_d = '0;
          served_d  = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mask    <= '1;
      estatus <= '0;
      served  <= '0;
      ack_q   <= '0;
      dfault  <= 1'b0;
    end else begin
      state   <= state_d;
      estatus <= estatus_d;
      served  <= served_d;
      ack_q   <= ack_d;
      if (mask_we) mask <= mask_wdata;
      if (exc_req_i && (state != IDLE)) dfault <= 1'b1;
    end
  end

  assign Exc_o     = (state == REQ);
  assign busy_o    = (state == HANDLER);
  assign EStatus_o = estatus;
  assign ExtIAck_o = ack_q;
  assign dfault_o  = dfault;

endmodule
